// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types and constants for the temperature-to-BCD converter
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_INT  = 2'd1,
    CONV_FRAC = 2'd2,
    DONE      = 2'd3
  } temp_state_t;

  localparam int INT_BITS   = 9;
  localparam int FRAC_BITS  = 4;
  localparam int FRAC_SCALE = 625;
  localparam int SHIFT_BITS = 14;
  localparam int BCD_BITS   = 16;

  // Last iteration index for each double-dabble phase (counter counts 0..N-1)
  localparam logic [3:0] INT_LAST  = 4'(INT_BITS - 1);
  localparam logic [3:0] FRAC_LAST = 4'(SHIFT_BITS - 1);

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_add3 (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule

// File: rtl/temp_to_bcd.sv
// rtl/temp_to_bcd.sv - ADT7420 13-bit word to sign + 3 integer + 4 fractional BCD digits
module temp_to_bcd
  import temp_pkg::*;
#(
  parameter int FRAC_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] temp_data,
  output logic        out_valid,
  output logic        sign,
  output logic [11:0] bcd_int,
  output logic [15:0] bcd_frac,
  output logic [2:0]  int_blank,
  output logic        overrun
);

  // Keep only the leading FRAC_DIGITS fractional digits; the rest read as zero (truncation)
  localparam int              FRAC_SH   = 4 * (4 - FRAC_DIGITS);
  localparam logic [15:0]     FRAC_MASK = 16'hFFFF << FRAC_SH;

  temp_state_t                 state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        sign_lat_q, sign_lat_d;
  logic [FRAC_BITS-1:0]        frac4_q, frac4_d;
  logic [SHIFT_BITS-1:0]       bin_q, bin_d;
  logic [BCD_BITS-1:0]         bcd_q, bcd_d;
  logic [11:0]                 int_res_q, int_res_d;

  logic                        out_valid_q, out_valid_d;
  logic                        sign_q, sign_d;
  logic [11:0]                 bcd_int_q, bcd_int_d;
  logic [15:0]                 bcd_frac_q, bcd_frac_d;
  logic [2:0]                  int_blank_q, int_blank_d;
  logic                        overrun_q, overrun_d;

  logic [12:0]                 t13;
  logic [12:0]                 mag;
  logic [SHIFT_BITS-1:0]       frac_scaled;
  logic [BCD_BITS-1:0]         bcd_fix;
  logic [BCD_BITS-1:0]         bcd_shift;
  logic                        unused_bits;

  // Shared correction stage: one add-3 per BCD nibble, feeding the shift
  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd_q[4*g +: 4]),
      .nib_out (bcd_fix[4*g +: 4])
    );
  end

  assign bcd_shift   = {bcd_fix[BCD_BITS-2:0], bin_q[SHIFT_BITS-1]};
  assign t13         = temp_data[15:3];
  assign mag         = t13[12] ? (~t13 + 13'd1) : t13;
  assign frac_scaled = 14'(frac4_q) * 14'(FRAC_SCALE);
  assign unused_bits = ^{temp_data[2:0], bcd_fix[BCD_BITS-1]};
  assign in_ready    = (state_q == IDLE);

  // Next-state and datapath: accept, integer dabble, fraction dabble, publish
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_lat_d  = sign_lat_q;
    frac4_d     = frac4_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    int_res_d   = int_res_q;
    out_valid_d = 1'b0;
    sign_d      = sign_q;
    bcd_int_d   = bcd_int_q;
    bcd_frac_d  = bcd_frac_q;
    int_blank_d = int_blank_q;
    overrun_d   = in_valid & ~in_ready;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_lat_d = t13[12];
          frac4_d    = mag[FRAC_BITS-1:0];
          // Integer part sits at the top of the shifter so 9 shifts move it all out
          bin_d      = {mag[12:4], 5'b0};
          bcd_d      = '0;
          cnt_d      = 4'd0;
          state_d    = LOAD_INT;
        end
      end
      LOAD_INT: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == INT_LAST) begin
          // Park the integer digits and reuse the engine for the scaled fraction
          int_res_d = bcd_shift[11:0];
          bin_d     = frac_scaled;
          bcd_d     = '0;
          cnt_d     = 4'd0;
          state_d   = CONV_FRAC;
        end
      end
      CONV_FRAC: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == FRAC_LAST) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        sign_d      = sign_lat_q;
        bcd_int_d   = int_res_q;
        bcd_frac_d  = bcd_q & FRAC_MASK;
        int_blank_d = {(int_res_q[11:8] == 4'd0),
                       (int_res_q[11:8] == 4'd0) && (int_res_q[7:4] == 4'd0),
                       1'b0};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sign_lat_q  <= 1'b0;
      frac4_q     <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      int_res_q   <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      bcd_int_q   <= '0;
      bcd_frac_q  <= '0;
      int_blank_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_lat_q  <= sign_lat_d;
      frac4_q     <= frac4_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      int_res_q   <= int_res_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      bcd_int_q   <= bcd_int_d;
      bcd_frac_q  <= bcd_frac_d;
      int_blank_q <= int_blank_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign bcd_int   = bcd_int_q;
  assign bcd_frac  = bcd_frac_q;
  assign int_blank = int_blank_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_temp_to_bcd.sv
// tb/tb_temp_to_bcd.sv - scoreboard bench for temp_to_bcd (default and two-digit fraction)
module tb_temp_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] temp_data;

  logic        in_ready, out_valid, sign, overrun;
  logic [11:0] bcd_int;
  logic [15:0] bcd_frac;
  logic [2:0]  int_blank;

  logic        in_ready2, out_valid2, sign2, overrun2;
  logic [11:0] bcd_int2;
  logic [15:0] bcd_frac2;
  logic [2:0]  int_blank2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    logic        s;
    logic [11:0] bi;
    logic [15:0] bf;
    logic [2:0]  bl;
  } vec_t;

  typedef struct {
    logic        s;
    logic [11:0] bi;
    logic [15:0] bf;
    logic [2:0]  bl;
    int          acc;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[12];

  temp_to_bcd dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .temp_data(temp_data), .out_valid(out_valid), .sign(sign), .bcd_int(bcd_int),
    .bcd_frac(bcd_frac), .int_blank(int_blank), .overrun(overrun)
  );

  temp_to_bcd #(.FRAC_DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .temp_data(temp_data), .out_valid(out_valid2), .sign(sign2), .bcd_int(bcd_int2),
    .bcd_frac(bcd_frac2), .int_blank(int_blank2), .overrun(overrun2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference conversion by integer arithmetic, independent of the shift engine
  function automatic sb_t model(input logic [15:0] w);
    sb_t e;
    int  t, m, ip, fr;
    t  = int'(w[15:3]);
    e.s = w[15];
    m  = e.s ? (8192 - t) : t;
    ip = m / 16;
    fr = (m % 16) * 625;
    e.bi = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
    e.bf = {4'(fr / 1000), 4'((fr / 100) % 10), 4'((fr / 10) % 10), 4'(fr % 10)};
    e.bl = {(ip < 100), (ip < 10), 1'b0};
    e.acc = 0;
    return e;
  endfunction

  // Drive one word when the block is ready; push its expectation at the accept edge
  task automatic send(input logic [15:0] w, input sb_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    temp_data = w;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("latency",       32'(cyc - e.acc), 32'd24);
        check("sign",          32'(sign),        32'(e.s));
        check("bcd_int",       32'(bcd_int),     32'(e.bi));
        check("bcd_frac",      32'(bcd_frac),    32'(e.bf));
        check("int_blank",     32'(int_blank),   32'(e.bl));
        check("out_valid2",    32'(out_valid2),  32'd1);
        check("sign2",         32'(sign2),       32'(e.s));
        check("bcd_int2",      32'(bcd_int2),    32'(e.bi));
        check("bcd_frac2",     32'(bcd_frac2),   32'(e.bf & 16'hFF00));
        check("int_blank2",    32'(int_blank2),  32'(e.bl));
      end
    end
  end

  initial begin
    sb_t e;
    tbl[0]  = '{16'h0A40, 1'b0, 12'h020, 16'h5000, 3'b100};
    tbl[1]  = '{16'hFFF8, 1'b1, 12'h000, 16'h0625, 3'b110};
    tbl[2]  = '{16'h4B00, 1'b0, 12'h150, 16'h0000, 3'b000};
    tbl[3]  = '{16'h8000, 1'b1, 12'h256, 16'h0000, 3'b000};
    tbl[4]  = '{16'h0A48, 1'b0, 12'h020, 16'h5625, 3'b100};
    tbl[5]  = '{16'h7FF8, 1'b0, 12'h255, 16'h9375, 3'b000};
    tbl[6]  = '{16'h0000, 1'b0, 12'h000, 16'h0000, 3'b110};
    tbl[7]  = '{16'h0C87, 1'b0, 12'h025, 16'h0000, 3'b100};
    tbl[8]  = '{16'hE440, 1'b1, 12'h055, 16'h5000, 3'b100};
    tbl[9]  = '{16'hFF80, 1'b1, 12'h001, 16'h0000, 3'b110};
    tbl[10] = '{16'h0008, 1'b0, 12'h000, 16'h0625, 3'b110};
    tbl[11] = '{16'h0648, 1'b0, 12'h012, 16'h5625, 3'b100};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    temp_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign",      32'(sign),      32'd0);
    check("rst_bcd_int",   32'(bcd_int),   32'd0);
    check("rst_bcd_frac",  32'(bcd_frac),  32'd0);
    check("rst_int_blank", 32'(int_blank), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back to back
    for (int i = 0; i < 12; i++) begin
      e = '{tbl[i].s, tbl[i].bi, tbl[i].bf, tbl[i].bl, 0};
      send(tbl[i].data, e);
    end
    drain();

    // Random words against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      send(w, model(w));
    end
    drain();

    // Busy input: word offered at E5 is dropped and flagged, conversion continues
    send(16'h0A40, '{1'b0, 12'h020, 16'h5000, 3'b100, 0});
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b1;
    temp_data = 16'h4B00;
    @(posedge clk);
    #1;
    check("overrun_at_e5",  32'(overrun),  32'd1);
    check("busy_in_ready",  32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("overrun_one_cycle", 32'(overrun), 32'd0);
    repeat (17) @(posedge clk);
    #1;
    check("in_ready_low_e23", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_high_e24", 32'(in_ready),  32'd1);
    check("out_valid_e24",     32'(out_valid), 32'd1);
    drain();

    // Reset mid-conversion at E12 clears everything; next word converts cleanly
    send(16'h4B00, '{1'b0, 12'h150, 16'h0000, 3'b000, 0});
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sign",      32'(sign),      32'd0);
    check("midrst_bcd_int",   32'(bcd_int),   32'd0);
    check("midrst_bcd_frac",  32'(bcd_frac),  32'd0);
    check("midrst_int_blank", 32'(int_blank), 32'd0);
    check("midrst_overrun",   32'(overrun),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'hFFF8, '{1'b1, 12'h000, 16'h0625, 3'b110, 0});
    drain();
    repeat (30) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
